vga_rect_fill: RTL and testbench

Rectangle-fill pixel generator that sits directly upstream of the VGA output core and drives its pixel-write inputs (`x_in`, `y_in`, `r_in`, `g_in`, `b_in`). It accepts one rectangle command at a time over a valid/ready handshake, clips the rectangle to the active display area, and emits one pixel write per accepted handshake in raster order. Drawing engines use it to clear screens and paint solid regions without per-pixel software loops.

---
 rtl/vga_rect_fill.sv | 169 ++++++++++++++++
 tb/tb_vga_rect_fill.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_rect_fill.sv
// Rectangle-fill pixel generator: accepts one rectangle command, clips it to the
// active display area and streams its pixels in raster order to the VGA write port.
module vga_rect_fill #(
    parameter int H_ACTIVE      = 640,
    parameter int V_ACTIVE      = 480,
    parameter int X_WIDTH       = 10,
    parameter int Y_WIDTH       = 9,
    parameter int CHANNEL_SIZES = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [X_WIDTH-1:0]       cmd_x,
    input  logic [X_WIDTH-1:0]       cmd_w,
    input  logic [Y_WIDTH-1:0]       cmd_y,
    input  logic [Y_WIDTH-1:0]       cmd_h,
    input  logic [CHANNEL_SIZES-1:0] cmd_r,
    input  logic [CHANNEL_SIZES-1:0] cmd_g,
    input  logic [CHANNEL_SIZES-1:0] cmd_b,
    output logic                     plot,
    input  logic                     plot_ready,
    output logic [X_WIDTH-1:0]       x_out,
    output logic [Y_WIDTH-1:0]       y_out,
    output logic [CHANNEL_SIZES-1:0] r_out,
    output logic [CHANNEL_SIZES-1:0] g_out,
    output logic [CHANNEL_SIZES-1:0] b_out,
    output logic                     busy,
    output logic                     done
);

    localparam int XW1 = X_WIDTH + 1;
    localparam int YW1 = Y_WIDTH + 1;
    localparam logic [X_WIDTH:0] H_LIMIT = XW1'(H_ACTIVE);
    localparam logic [Y_WIDTH:0] V_LIMIT = YW1'(V_ACTIVE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic                     plot_q, plot_d;
    logic [X_WIDTH-1:0]       x_q, x_d;
    logic [Y_WIDTH-1:0]       y_q, y_d;
    logic [X_WIDTH-1:0]       xStart_q, xStart_d;
    logic [X_WIDTH:0]         xEnd_q, xEnd_d;
    logic [Y_WIDTH:0]         yEnd_q, yEnd_d;
    logic [CHANNEL_SIZES-1:0] r_q, r_d;
    logic [CHANNEL_SIZES-1:0] g_q, g_d;
    logic [CHANNEL_SIZES-1:0] b_q, b_d;

    logic [X_WIDTH:0] xSum;
    logic [Y_WIDTH:0] ySum;
    logic [X_WIDTH:0] xClip;
    logic [Y_WIDTH:0] yClip;
    logic [X_WIDTH:0] xNext;
    logic [Y_WIDTH:0] yNext;
    logic             cmdEmpty;
    logic             cmdAccept;
    logic             pixelTaken;

    // End coordinates are exclusive and one bit wider than the coordinates, so x+w never wraps.
    assign xSum  = {1'b0, cmd_x} + {1'b0, cmd_w};
    assign ySum  = {1'b0, cmd_y} + {1'b0, cmd_h};
    assign xClip = (xSum > H_LIMIT) ? H_LIMIT : xSum;
    assign yClip = (ySum > V_LIMIT) ? V_LIMIT : ySum;

    assign cmdEmpty = (cmd_w == '0) || (cmd_h == '0) ||
                      ({1'b0, cmd_x} >= H_LIMIT) || ({1'b0, cmd_y} >= V_LIMIT);

    assign cmdAccept  = cmd_valid && cmd_ready;
    assign pixelTaken = plot_q && plot_ready;
    assign xNext      = {1'b0, x_q} + XW1'(1);
    assign yNext      = {1'b0, y_q} + YW1'(1);

    always_comb begin
        state_d  = state_q;
        plot_d   = plot_q;
        x_d      = x_q;
        y_d      = y_q;
        xStart_d = xStart_q;
        xEnd_d   = xEnd_q;
        yEnd_d   = yEnd_q;
        r_d      = r_q;
        g_d      = g_q;
        b_d      = b_q;

        case (state_q)
            IDLE: begin
                if (cmdAccept) begin
                    r_d      = cmd_r;
                    g_d      = cmd_g;
                    b_d      = cmd_b;
                    xStart_d = cmd_x;
                    xEnd_d   = xClip;
                    yEnd_d   = yClip;
                    if (cmdEmpty) begin
                        state_d = DONE;
                    end else begin
                        x_d     = cmd_x;
                        y_d     = cmd_y;
                        plot_d  = 1'b1;
                        state_d = FILL;
                    end
                end
            end
            FILL: begin
                // Advance only on a taken pixel so stalls hold position and colour.
                if (pixelTaken) begin
                    if (xNext < xEnd_q) begin
                        x_d = xNext[X_WIDTH-1:0];
                    end else if (yNext < yEnd_q) begin
                        x_d = xStart_q;
                        y_d = yNext[Y_WIDTH-1:0];
                    end else begin
                        plot_d  = 1'b0;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                plot_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            plot_q   <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            xStart_q <= '0;
            xEnd_q   <= '0;
            yEnd_q   <= '0;
            r_q      <= '0;
            g_q      <= '0;
            b_q      <= '0;
        end else begin
            state_q  <= state_d;
            plot_q   <= plot_d;
            x_q      <= x_d;
            y_q      <= y_d;
            xStart_q <= xStart_d;
            xEnd_q   <= xEnd_d;
            yEnd_q   <= yEnd_d;
            r_q      <= r_d;
            g_q      <= g_d;
            b_q      <= b_d;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign plot      = plot_q;
    assign x_out     = x_q;
    assign y_out     = y_q;
    assign r_out     = r_q;
    assign g_out     = g_q;
    assign b_out     = b_q;

endmodule

// File: tb/tb_vga_rect_fill.sv
// Self-checking bench for vga_rect_fill: directed scenarios plus randomized commands
// compared against a rectangle-enumeration reference model.
module tb_vga_rect_fill;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       plot_ready = 1'b0;
    logic [9:0] cmd_x = '0;
    logic [9:0] cmd_w = '0;
    logic [8:0] cmd_y = '0;
    logic [8:0] cmd_h = '0;
    logic [7:0] cmd_r = '0;
    logic [7:0] cmd_g = '0;
    logic [7:0] cmd_b = '0;
    logic       cmd_ready, plot, busy, done;
    logic [9:0] x_out;
    logic [8:0] y_out;
    logic [7:0] r_out, g_out, b_out;

    vga_rect_fill #(
        .H_ACTIVE(640), .V_ACTIVE(480), .X_WIDTH(10), .Y_WIDTH(9), .CHANNEL_SIZES(8)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_x(cmd_x), .cmd_w(cmd_w), .cmd_y(cmd_y), .cmd_h(cmd_h),
        .cmd_r(cmd_r), .cmd_g(cmd_g), .cmd_b(cmd_b),
        .plot(plot), .plot_ready(plot_ready),
        .x_out(x_out), .y_out(y_out),
        .r_out(r_out), .g_out(g_out), .b_out(b_out),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [7:0]  r;
        logic [7:0]  g;
        logic [7:0]  b;
    } pix_t;

    int   compared = 0;
    int   mismatched = 0;
    pix_t obs[$];
    pix_t expq[$];
    int   readyPat[$];
    int   readyMode;
    int   firstPlot, doneCycle, lastAccept, stallChanges, statusBad, waitCycles;
    bit   timedOut, plotAtDone;
    logic readyAfter, doneAfter, busyAfter;
    bit   holdNext = 1'b0;
    int   nextX, nextY, nextW, nextH, nextR, nextG, nextB;

    function automatic bit isEmpty(int x, int y, int w, int h);
        return (w == 0) || (h == 0) || (x >= 640) || (y >= 480);
    endfunction

    // Reference: every pixel of the rectangle intersected with the screen, row by row.
    function automatic void buildExpected(int x, int y, int w, int h, int r, int g, int b);
        int xe, ye;
        expq.delete();
        if (isEmpty(x, y, w, h)) return;
        xe = (x + w < 640) ? x + w : 640;
        ye = (y + h < 480) ? y + h : 480;
        for (int yy = y; yy < ye; yy++)
            for (int xx = x; xx < xe; xx++)
                expq.push_back(pix_t'{16'(xx), 16'(yy), 8'(r), 8'(g), 8'(b)});
    endfunction

    task automatic applyStimulus(input int x, y, w, h, r, g, b, input int stopAfter);
        logic       rdy;
        bit         prevStall;
        logic [9:0] px;
        logic [8:0] py;
        logic [7:0] pr, pg, pb;
        obs.delete();
        firstPlot = -1; doneCycle = -1; lastAccept = -1;
        stallChanges = 0; statusBad = 0; waitCycles = 0;
        timedOut = 1'b0; plotAtDone = 1'b0; prevStall = 1'b0;
        px = '0; py = '0; pr = '0; pg = '0; pb = '0;
        while (!cmd_ready && waitCycles < 100) begin
            @(negedge clk);
            waitCycles++;
        end
        if (!cmd_ready) begin
            timedOut = 1'b1;
            return;
        end
        cmd_valid = 1'b1;
        cmd_x = 10'(x); cmd_y = 9'(y); cmd_w = 10'(w); cmd_h = 9'(h);
        cmd_r = 8'(r); cmd_g = 8'(g); cmd_b = 8'(b);
        @(negedge clk);
        if (holdNext) begin
            cmd_x = 10'(nextX); cmd_y = 9'(nextY); cmd_w = 10'(nextW); cmd_h = 9'(nextH);
            cmd_r = 8'(nextR); cmd_g = 8'(nextG); cmd_b = 8'(nextB);
        end else begin
            cmd_valid = 1'b0;
        end
        for (int c = 1; c <= 20000; c++) begin
            if (plot) begin
                if (firstPlot < 0) firstPlot = c;
                if (prevStall && (x_out !== px || y_out !== py || r_out !== pr ||
                                  g_out !== pg || b_out !== pb))
                    stallChanges++;
            end
            if (busy !== 1'b1 || cmd_ready !== 1'b0) statusBad++;
            if (done) begin
                doneCycle  = c;
                plotAtDone = plot;
                plot_ready = 1'b0;
                @(negedge clk);
                readyAfter = cmd_ready;
                doneAfter  = done;
                busyAfter  = busy;
                return;
            end
            if (readyMode == 0) rdy = 1'b1;
            else if (readyMode == 1) rdy = (readyPat.size() > 0) ? (readyPat.pop_front() != 0) : 1'b1;
            else rdy = ($urandom_range(0, 3) != 0);
            plot_ready = rdy;
            if (plot && rdy) begin
                obs.push_back(pix_t'{16'(x_out), 16'(y_out), r_out, g_out, b_out});
                lastAccept = c;
            end
            prevStall = plot && !rdy;
            px = x_out; py = y_out; pr = r_out; pg = g_out; pb = b_out;
            if (stopAfter >= 0 && obs.size() == stopAfter) begin
                @(negedge clk);
                plot_ready = 1'b0;
                return;
            end
            @(negedge clk);
        end
        timedOut = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        compared++;
        if ({cmd_ready, busy, done, plot} !== 4'b1000) begin
            mismatched++;
            $display("[TB] FAIL reset_status: got ready/busy/done/plot=%b required 1000", {cmd_ready, busy, done, plot});
        end
        compared++;
        if (x_out !== 10'd0 || y_out !== 9'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_coords: got (%0d,%0d) required (0,0)", x_out, y_out);
        end
        compared++;
        if ({r_out, g_out, b_out} !== 24'h0) begin
            mismatched++;
            $display("[TB] FAIL reset_colour: got %h required 000000", {r_out, g_out, b_out});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic_fill();
        readyMode = 0;
        buildExpected(10, 20, 2, 2, 'hFF, 'h00, 'h80);
        applyStimulus(10, 20, 2, 2, 'hFF, 'h00, 'h80, -1);
        compared++;
        if (timedOut || obs.size() != expq.size()) begin
            mismatched++;
            $display("[TB] FAIL basic_count: got %0d pixels (timeout=%0d) required %0d", obs.size(), timedOut, expq.size());
        end
        for (int i = 0; i < obs.size() && i < expq.size(); i++) begin
            compared++;
            if (obs[i] !== expq[i]) begin
                mismatched++;
                $display("[TB] FAIL basic_pixel%0d: got %h required %h", i, obs[i], expq[i]);
            end
        end
        compared++;
        if (firstPlot != 1 || lastAccept != 4 || doneCycle != 5) begin
            mismatched++;
            $display("[TB] FAIL basic_timing: got first/last/done=%0d/%0d/%0d required 1/4/5", firstPlot, lastAccept, doneCycle);
        end
        compared++;
        if (readyAfter !== 1'b1 || doneAfter !== 1'b0 || busyAfter !== 1'b0 || plotAtDone || statusBad != 0) begin
            mismatched++;
            $display("[TB] FAIL basic_status: got ready/done/busy after=%b%b%b plotAtDone=%0d bad=%0d required 100/0/0",
                     readyAfter, doneAfter, busyAfter, plotAtDone, statusBad);
        end
    endtask

    task automatic test_backpressure();
        readyMode = 1;
        readyPat = '{1, 0, 0, 1, 0, 1};
        buildExpected(0, 0, 3, 1, 'h12, 'h34, 'h56);
        applyStimulus(0, 0, 3, 1, 'h12, 'h34, 'h56, -1);
        compared++;
        if (timedOut || obs.size() != 3) begin
            mismatched++;
            $display("[TB] FAIL bp_count: got %0d pixels (timeout=%0d) required 3", obs.size(), timedOut);
        end
        for (int i = 0; i < obs.size() && i < expq.size(); i++) begin
            compared++;
            if (obs[i] !== expq[i]) begin
                mismatched++;
                $display("[TB] FAIL bp_pixel%0d: got %h required %h", i, obs[i], expq[i]);
            end
        end
        compared++;
        if (stallChanges != 0) begin
            mismatched++;
            $display("[TB] FAIL bp_stall_hold: got %0d changes during stalls required 0", stallChanges);
        end
        compared++;
        if (lastAccept != 6 || doneCycle != 7) begin
            mismatched++;
            $display("[TB] FAIL bp_timing: got last/done=%0d/%0d required 6/7", lastAccept, doneCycle);
        end
    endtask

    task automatic test_clipping();
        readyMode = 0;
        buildExpected(638, 478, 5, 3, 'hA5, 'h5A, 'hC3);
        applyStimulus(638, 478, 5, 3, 'hA5, 'h5A, 'hC3, -1);
        compared++;
        if (timedOut || obs.size() != 4 || expq.size() != 4) begin
            mismatched++;
            $display("[TB] FAIL clip_count: got %0d pixels (timeout=%0d) required 4", obs.size(), timedOut);
        end
        for (int i = 0; i < obs.size() && i < expq.size(); i++) begin
            compared++;
            if (obs[i] !== expq[i]) begin
                mismatched++;
                $display("[TB] FAIL clip_pixel%0d: got %h required %h", i, obs[i], expq[i]);
            end
        end
        compared++;
        if (doneCycle != 5 || plotAtDone) begin
            mismatched++;
            $display("[TB] FAIL clip_done: got done cycle %0d plot=%0d required 5 with plot 0", doneCycle, plotAtDone);
        end
    endtask

    task automatic test_empty();
        int tbl[4][4] = '{'{10, 10, 0, 5}, '{700, 10, 4, 4}, '{3, 7, 9, 0}, '{20, 500, 5, 5}};
        readyMode = 0;
        foreach (tbl[i]) begin
            applyStimulus(tbl[i][0], tbl[i][1], tbl[i][2], tbl[i][3], 'h11, 'h22, 'h33, -1);
            compared++;
            if (timedOut || firstPlot != -1 || obs.size() != 0) begin
                mismatched++;
                $display("[TB] FAIL empty%0d_plot: got first plot cycle %0d, %0d pixels required none", i, firstPlot, obs.size());
            end
            compared++;
            if (doneCycle != 1 || readyAfter !== 1'b1 || doneAfter !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL empty%0d_timing: got done cycle %0d ready after %b required 1 and 1", i, doneCycle, readyAfter);
            end
        end
    endtask

    task automatic test_reset_mid_fill();
        readyMode = 0;
        buildExpected(0, 0, 100, 100, 'h77, 'h88, 'h99);
        applyStimulus(0, 0, 100, 100, 'h77, 'h88, 'h99, 37);
        compared++;
        if (timedOut || obs.size() != 37) begin
            mismatched++;
            $display("[TB] FAIL rmf_count: got %0d pixels before reset required 37", obs.size());
        end
        for (int i = 0; i < obs.size() && i < 37; i++) begin
            compared++;
            if (obs[i] !== expq[i]) begin
                mismatched++;
                $display("[TB] FAIL rmf_pixel%0d: got %h required %h", i, obs[i], expq[i]);
            end
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        compared++;
        if ({plot, cmd_ready, done, busy} !== 4'b0100 || x_out !== 10'd0 || y_out !== 9'd0 || r_out !== 8'd0) begin
            mismatched++;
            $display("[TB] FAIL rmf_after_reset: got plot/ready/done/busy=%b (%0d,%0d) r=%h required 0100 (0,0) r=00",
                     {plot, cmd_ready, done, busy}, x_out, y_out, r_out);
        end
        buildExpected(5, 5, 1, 1, 'h01, 'h02, 'h03);
        applyStimulus(5, 5, 1, 1, 'h01, 'h02, 'h03, -1);
        compared++;
        if (timedOut || obs.size() != 1 || obs[0] !== expq[0] || doneCycle != 2) begin
            mismatched++;
            $display("[TB] FAIL rmf_new_cmd: got %0d pixels first=%h done=%0d required 1 pixel %h done=2",
                     obs.size(), (obs.size() > 0) ? obs[0] : '0, doneCycle, expq[0]);
        end
    endtask

    task automatic test_back_to_back();
        readyMode = 0;
        nextX = 300; nextY = 50; nextW = 2; nextH = 3; nextR = 'hDE; nextG = 'hAD; nextB = 'hBE;
        holdNext = 1'b1;
        buildExpected(100, 200, 3, 2, 'h10, 'h20, 'h30);
        applyStimulus(100, 200, 3, 2, 'h10, 'h20, 'h30, -1);
        holdNext = 1'b0;
        compared++;
        if (timedOut || obs.size() != expq.size() || readyAfter !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL b2b_first: got %0d pixels ready after %b required %0d and 1", obs.size(), readyAfter, expq.size());
        end
        for (int i = 0; i < obs.size() && i < expq.size(); i++) begin
            compared++;
            if (obs[i] !== expq[i]) begin
                mismatched++;
                $display("[TB] FAIL b2b_first_pixel%0d: got %h required %h", i, obs[i], expq[i]);
            end
        end
        buildExpected(nextX, nextY, nextW, nextH, nextR, nextG, nextB);
        applyStimulus(nextX, nextY, nextW, nextH, nextR, nextG, nextB, -1);
        compared++;
        if (timedOut || waitCycles != 0 || firstPlot != 1 || obs.size() != expq.size()) begin
            mismatched++;
            $display("[TB] FAIL b2b_second: got wait=%0d first=%0d pixels=%0d required 0/1/%0d", waitCycles, firstPlot, obs.size(), expq.size());
        end
        for (int i = 0; i < obs.size() && i < expq.size(); i++) begin
            compared++;
            if (obs[i] !== expq[i]) begin
                mismatched++;
                $display("[TB] FAIL b2b_second_pixel%0d: got %h required %h", i, obs[i], expq[i]);
            end
        end
    endtask

    task automatic test_random();
        int x, y, w, h, r, g, b, expDone;
        readyMode = 2;
        for (int n = 0; n < 25; n++) begin
            x = ($urandom_range(0, 2) == 0) ? 640 - int'($urandom_range(1, 12)) : int'($urandom_range(0, 700));
            y = ($urandom_range(0, 2) == 0) ? 480 - int'($urandom_range(1, 8)) : int'($urandom_range(0, 500));
            w = $urandom_range(0, 30);
            h = $urandom_range(0, 12);
            r = $urandom_range(0, 255); g = $urandom_range(0, 255); b = $urandom_range(0, 255);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            buildExpected(x, y, w, h, r, g, b);
            applyStimulus(x, y, w, h, r, g, b, -1);
            compared++;
            if (timedOut || obs.size() != expq.size()) begin
                mismatched++;
                $display("[TB] FAIL rand%0d_count: got %0d pixels (timeout=%0d) required %0d for (%0d,%0d,%0d,%0d)",
                         n, obs.size(), timedOut, expq.size(), x, y, w, h);
            end
            for (int i = 0; i < obs.size() && i < expq.size(); i++) begin
                compared++;
                if (obs[i] !== expq[i]) begin
                    mismatched++;
                    $display("[TB] FAIL rand%0d_pixel%0d: got %h required %h", n, i, obs[i], expq[i]);
                    break;
                end
            end
            expDone = (expq.size() == 0) ? 1 : lastAccept + 1;
            compared++;
            if (doneCycle != expDone || stallChanges != 0 || statusBad != 0 || plotAtDone || readyAfter !== 1'b1) begin
                mismatched++;
                $display("[TB] FAIL rand%0d_protocol: got done=%0d stallChg=%0d bad=%0d readyAfter=%b required done=%0d 0 0 1",
                         n, doneCycle, stallChanges, statusBad, readyAfter, expDone);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_fill();
        test_backpressure();
        test_clipping();
        test_empty();
        test_reset_mid_fill();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
